uart_rx_fifo: RTL and testbench

- Parametrised successor to the board-level Arduino serial receiver: a UART receiver with configurable data width, parity mode, majority-vote bit sampling, error flags and an output FIFO with a valid/ready handshake.
- Sits between the FPGA pin driven by the Arduino TX line and consumer logic (LED display, command decoder).
- Exposes its state encoding and the synchronised line level for LED debug.

---
 rtl/uart_rx_fifo.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, optional parity, sticky error
// flags and a show-ahead output FIFO drained through a valid/ready handshake.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_serial,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        overrun,
  input  logic                        err_clear,
  output logic [2:0]                  state,
  output logic                        rx_sync
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int NW   = AW + 1;
  localparam int MID  = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state, w_state_next;
  logic                 r_sync1, r_sync2;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit_idx;
  logic                 r_samp_a, r_samp_b;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_acc, r_par_bad;
  logic                 r_frame_err, r_parity_err, r_overrun;
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [NW-1:0]        r_count;

  logic w_maj, w_cnt_last, w_decide, w_stop_decide;
  logic w_push, w_frame_set, w_parity_set, w_overrun_set;
  logic w_pop, w_full, w_wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      // NOTE: non-blocking so each stage takes the pre-edge value; blocking would collapse the two flops into one.
      r_sync1 <= rx_serial;
      r_sync2 <= r_sync1;
    end
  end

  assign rx_sync = r_sync2;

  // Third vote is the live sample taken at the decision count MID+1.
  assign w_maj = (r_samp_a & r_samp_b) | (r_samp_a & r_sync2) | (r_samp_b & r_sync2);
  assign w_cnt_last    = (r_cnt == CW'(CLKS_PER_BIT - 1));
  assign w_decide      = (r_cnt == CW'(MID + 1));
  assign w_stop_decide = (r_state == S_STOP) && w_decide;

  always_comb begin
    // NOTE: default assigned first so every path drives w_state_next; a missing branch would infer a latch.
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:   if (!r_sync2) w_state_next = S_START;
      S_START: begin
        if (w_decide && w_maj) w_state_next = S_IDLE;
        else if (w_cnt_last)   w_state_next = S_DATA;
      end
      S_DATA: begin
        if (w_cnt_last && (r_bit_idx == BW'(DATA_BITS - 1)))
          w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: if (w_cnt_last) w_state_next = S_STOP;
      S_STOP:   if (w_decide) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_samp_a  <= 1'b1;
      r_samp_b  <= 1'b1;
      r_shift   <= '0;
      r_par_acc <= 1'b0;
      r_par_bad <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE || w_state_next == S_IDLE || w_cnt_last) r_cnt <= '0;
      else                                                            r_cnt <= r_cnt + CW'(1);
      if (r_cnt == CW'(MID - 1)) r_samp_a <= r_sync2;
      if (r_cnt == CW'(MID))     r_samp_b <= r_sync2;
      if (r_state == S_IDLE) begin
        r_bit_idx <= '0;
        r_par_acc <= 1'b0;
        r_par_bad <= 1'b0;
      end
      if (r_state == S_DATA) begin
        if (w_decide) begin
          r_shift   <= {w_maj, r_shift[DATA_BITS-1:1]};
          r_par_acc <= r_par_acc ^ w_maj;
        end
        if (w_cnt_last) r_bit_idx <= r_bit_idx + BW'(1);
      end
      if (r_state == S_PARITY && w_decide)
        r_par_bad <= (PARITY == 1) ? ~(r_par_acc ^ w_maj) : (r_par_acc ^ w_maj);
    end
  end

  assign w_push        = w_stop_decide && w_maj && !r_par_bad;
  assign w_frame_set   = w_stop_decide && !w_maj;
  assign w_parity_set  = w_stop_decide && w_maj && r_par_bad;
  assign w_pop         = rx_valid && rx_ready;
  assign w_full        = (r_count == NW'(FIFO_DEPTH));
  assign w_wr_en       = w_push && (!w_full || w_pop);
  assign w_overrun_set = w_push && w_full && !w_pop;

  // NOTE: storage is deliberately not reset; pointers and count define validity and rx_data is don't-care when empty.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + NW'(1);
        2'b01:   r_count <= r_count - NW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A new error event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_frame_set)        r_frame_err  <= 1'b1;
      else if (err_clear)     r_frame_err  <= 1'b0;
      if (w_parity_set)       r_parity_err <= 1'b1;
      else if (err_clear)     r_parity_err <= 1'b0;
      if (w_overrun_set)      r_overrun    <= 1'b1;
      else if (err_clear)     r_overrun    <= 1'b0;
    end
  end

  assign rx_data    = r_mem[r_rd_ptr];
  assign rx_valid   = (r_count != '0);
  assign fifo_count = r_count;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;
  assign state      = r_state;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8N1 instance and an 8E1 instance share
// one serial driver, selected by use_p; all timing is 16 clocks per bit.
module tb_uart_rx_fifo;

  localparam int BIT = 16;

  logic clk, rst, rx_line, use_p;
  logic a_ready, a_clear, b_ready, b_clear;
  logic rx_a, rx_b;
  logic [7:0] a_data, b_data;
  logic a_valid, b_valid, a_ferr, b_ferr, a_perr, b_perr, a_ovr, b_ovr;
  logic [2:0] a_count, b_count, a_state, b_state;
  logic a_sync, b_sync;
  int n_checks = 0;
  int n_errors = 0;

  assign rx_a = use_p ? 1'b1 : rx_line;
  assign rx_b = use_p ? rx_line : 1'b1;

  uart_rx_fifo #(.CLKS_PER_BIT(BIT), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .rx_serial(rx_a), .rx_data(a_data), .rx_valid(a_valid),
    .rx_ready(a_ready), .fifo_count(a_count), .frame_err(a_ferr), .parity_err(a_perr),
    .overrun(a_ovr), .err_clear(a_clear), .state(a_state), .rx_sync(a_sync));

  uart_rx_fifo #(.CLKS_PER_BIT(BIT), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .rx_serial(rx_b), .rx_data(b_data), .rx_valid(b_valid),
    .rx_ready(b_ready), .fifo_count(b_count), .frame_err(b_ferr), .parity_err(b_perr),
    .overrun(b_ovr), .err_clear(b_clear), .state(b_state), .rx_sync(b_sync));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Starts on a negedge; leaves the line idle-high on return.
  task automatic send_frame(input logic [7:0] data, input bit has_par,
                            input bit par_bit, input bit stop_bit);
    rx_line = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = data[i];
      repeat (BIT) @(negedge clk);
    end
    if (has_par) begin
      rx_line = par_bit;
      repeat (BIT) @(negedge clk);
    end
    rx_line = stop_bit;
    repeat (BIT) @(negedge clk);
    rx_line = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (a_state !== 3'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", a_state); end
    n_checks++; if (a_sync !== 1'b1) begin n_errors++; $display("FAIL reset_rx_sync: got %b expected 1", a_sync); end
    n_checks++; if (a_valid !== 1'b0 || a_count !== 3'd0) begin n_errors++; $display("FAIL reset_fifo: got valid=%b count=%0d expected 0/0", a_valid, a_count); end
    n_checks++; if ({a_ferr, a_perr, a_ovr} !== 3'b000) begin n_errors++; $display("FAIL reset_flags: got %b expected 000", {a_ferr, a_perr, a_ovr}); end
    n_checks++; if (b_state !== 3'd0 || b_count !== 3'd0) begin n_errors++; $display("FAIL reset_b: got state=%0d count=%0d expected 0/0", b_state, b_count); end
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 0, 0, 1);
    n_checks++; if (a_valid !== 1'b1) begin n_errors++; $display("FAIL basic_valid: got %b expected 1", a_valid); end
    n_checks++; if (a_data !== 8'hA5) begin n_errors++; $display("FAIL basic_data: got %h expected a5", a_data); end
    n_checks++; if (a_count !== 3'd1) begin n_errors++; $display("FAIL basic_count: got %0d expected 1", a_count); end
    n_checks++; if ({a_ferr, a_perr, a_ovr} !== 3'b000) begin n_errors++; $display("FAIL basic_flags: got %b expected 000", {a_ferr, a_perr, a_ovr}); end
    a_ready = 1'b1;
    @(negedge clk);
    a_ready = 1'b0;
    n_checks++; if (a_valid !== 1'b0 || a_count !== 3'd0) begin n_errors++; $display("FAIL basic_pop: got valid=%b count=%0d expected 0/0", a_valid, a_count); end
  endtask

  task automatic test_pop_empty();
    a_ready = 1'b1;
    repeat (3) @(negedge clk);
    a_ready = 1'b0;
    n_checks++; if (a_count !== 3'd0 || a_valid !== 1'b0) begin n_errors++; $display("FAIL pop_empty: got count=%0d valid=%b expected 0/0", a_count, a_valid); end
  endtask

  task automatic test_parity();
    use_p = 1'b1;
    @(negedge clk);
    send_frame(8'h37, 1, 0, 1);
    n_checks++; if (b_perr !== 1'b1) begin n_errors++; $display("FAIL parity_bad_flag: got %b expected 1", b_perr); end
    n_checks++; if (b_count !== 3'd0 || b_ferr !== 1'b0) begin n_errors++; $display("FAIL parity_bad_drop: got count=%0d ferr=%b expected 0/0", b_count, b_ferr); end
    b_clear = 1'b1;
    @(negedge clk);
    b_clear = 1'b0;
    n_checks++; if (b_perr !== 1'b0) begin n_errors++; $display("FAIL parity_clear: got %b expected 0", b_perr); end
    send_frame(8'h37, 1, 1, 1);
    n_checks++; if (b_valid !== 1'b1 || b_data !== 8'h37) begin n_errors++; $display("FAIL parity_good: got valid=%b data=%h expected 1/37", b_valid, b_data); end
    n_checks++; if (b_perr !== 1'b0) begin n_errors++; $display("FAIL parity_good_flag: got %b expected 0", b_perr); end
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    use_p = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_false_start_glitch();
    bit returned;
    rx_line = 1'b0;
    repeat (3) @(negedge clk);
    rx_line = 1'b1;
    n_checks++; if (a_state !== 3'd1) begin n_errors++; $display("FAIL false_start_enter: got %0d expected 1", a_state); end
    returned = 1'b0;
    for (int i = 0; i < BIT / 2 + 3 && !returned; i++) begin
      @(negedge clk);
      if (a_state === 3'd0) returned = 1'b1;
    end
    n_checks++; if (!returned) begin n_errors++; $display("FAIL false_start_return: got state=%0d expected 0 within %0d cycles", a_state, BIT / 2 + 3); end
    n_checks++; if (a_count !== 3'd0) begin n_errors++; $display("FAIL false_start_nopush: got %0d expected 0", a_count); end
    repeat (4) @(negedge clk);
    // 0x5A with bit 0 flipped for the single cycle seen as the MID sample.
    rx_line = 1'b0;
    repeat (BIT) @(negedge clk);
    rx_line = 1'b0;
    repeat (9) @(negedge clk);
    rx_line = 1'b1;
    @(negedge clk);
    rx_line = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 1; i < 8; i++) begin
      rx_line = (i == 1 || i == 3 || i == 4 || i == 6);
      repeat (BIT) @(negedge clk);
    end
    rx_line = 1'b1;
    repeat (BIT) @(negedge clk);
    n_checks++; if (a_valid !== 1'b1 || a_data !== 8'h5A) begin n_errors++; $display("FAIL glitch_vote: got valid=%b data=%h expected 1/5a", a_valid, a_data); end
    a_ready = 1'b1;
    @(negedge clk);
    a_ready = 1'b0;
  endtask

  task automatic test_fifo_overrun();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 0, 1);
    n_checks++; if (a_count !== 3'd4) begin n_errors++; $display("FAIL overrun_count: got %0d expected 4", a_count); end
    n_checks++; if (a_ovr !== 1'b1) begin n_errors++; $display("FAIL overrun_flag: got %b expected 1", a_ovr); end
    for (int i = 1; i <= 4; i++) begin
      n_checks++; if (a_data !== 8'(i)) begin n_errors++; $display("FAIL overrun_order%0d: got %h expected %h", i, a_data, 8'(i)); end
      a_ready = 1'b1;
      @(negedge clk);
      a_ready = 1'b0;
    end
    n_checks++; if (a_count !== 3'd0 || a_valid !== 1'b0) begin n_errors++; $display("FAIL overrun_drained: got count=%0d valid=%b expected 0/0", a_count, a_valid); end
  endtask

  task automatic test_full_push_pop();
    a_clear = 1'b1;
    @(negedge clk);
    a_clear = 1'b0;
    n_checks++; if (a_ovr !== 1'b0) begin n_errors++; $display("FAIL full_clear: got %b expected 0", a_ovr); end
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 0, 0, 1);
    n_checks++; if (a_count !== 3'd4) begin n_errors++; $display("FAIL full_fill: got %0d expected 4", a_count); end
    // The stop decision of a frame starting on this negedge lands on posedge 157.
    fork
      send_frame(8'h15, 0, 0, 1);
      begin
        repeat (156) @(negedge clk);
        a_ready = 1'b1;
        @(negedge clk);
        a_ready = 1'b0;
      end
    join
    n_checks++; if (a_count !== 3'd4) begin n_errors++; $display("FAIL full_pushpop_count: got %0d expected 4", a_count); end
    n_checks++; if (a_ovr !== 1'b0) begin n_errors++; $display("FAIL full_pushpop_ovr: got %b expected 0", a_ovr); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (a_data !== 8'h12 + 8'(i)) begin n_errors++; $display("FAIL full_order%0d: got %h expected %h", i, a_data, 8'h12 + 8'(i)); end
      a_ready = 1'b1;
      @(negedge clk);
      a_ready = 1'b0;
    end
  endtask

  task automatic test_frame_err();
    send_frame(8'h55, 0, 0, 0);
    n_checks++; if (a_ferr !== 1'b1) begin n_errors++; $display("FAIL frame_err_flag: got %b expected 1", a_ferr); end
    n_checks++; if (a_count !== 3'd0) begin n_errors++; $display("FAIL frame_err_drop: got %0d expected 0", a_count); end
    repeat (2 * BIT) @(negedge clk);
    n_checks++; if (a_state !== 3'd0) begin n_errors++; $display("FAIL frame_err_idle: got %0d expected 0", a_state); end
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'h21, 0, 0, 1);
    send_frame(8'h22, 0, 0, 1);
    n_checks++; if (a_count !== 3'd2) begin n_errors++; $display("FAIL midrst_queued: got %0d expected 2", a_count); end
    rx_line = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_line = ~rx_line;
      repeat (BIT) @(negedge clk);
    end
    repeat (BIT / 2) @(negedge clk);
    n_checks++; if (a_state !== 3'd2) begin n_errors++; $display("FAIL midrst_in_data: got %0d expected 2", a_state); end
    rst = 1'b1;
    rx_line = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (a_state !== 3'd0) begin n_errors++; $display("FAIL midrst_state: got %0d expected 0", a_state); end
    n_checks++; if (a_count !== 3'd0 || a_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_flush: got count=%0d valid=%b expected 0/0", a_count, a_valid); end
    n_checks++; if ({a_ferr, a_perr, a_ovr} !== 3'b000) begin n_errors++; $display("FAIL midrst_flags: got %b expected 000", {a_ferr, a_perr, a_ovr}); end
    repeat (4) @(negedge clk);
    send_frame(8'h3C, 0, 0, 1);
    n_checks++; if (a_valid !== 1'b1 || a_data !== 8'h3C || a_count !== 3'd1) begin n_errors++; $display("FAIL midrst_next: got valid=%b data=%h count=%0d expected 1/3c/1", a_valid, a_data, a_count); end
  endtask

  initial begin
    rx_line = 1'b1;
    use_p   = 1'b0;
    a_ready = 1'b0;
    a_clear = 1'b0;
    b_ready = 1'b0;
    b_clear = 1'b0;
    rst     = 1'b1;
    test_reset();
    test_basic();
    test_pop_empty();
    test_parity();
    test_false_start_glitch();
    test_fifo_overrun();
    test_full_push_pop();
    test_frame_err();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
